// File: rtl/rd_fram_gearbox_fifo_if.sv
// Bus bundle for the frame read-path gearbox FIFO: wide write side, narrow
// read side, status flags and sticky error indications.
interface rd_fram_gearbox_fifo_if #(
  parameter int WR_DATA_WIDTH = 256,
  parameter int RD_DATA_WIDTH = 32,
  parameter int DEPTH         = 512
);
  localparam int LVL_W = $clog2(DEPTH) + $clog2(WR_DATA_WIDTH / RD_DATA_WIDTH) + 1;

  logic                     flush;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     wr_en;
  logic                     full;
  logic                     afull;
  logic                     rd_en;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic                     rd_valid;
  logic                     empty;
  logic [LVL_W-1:0]         level;
  logic                     overflow;
  logic                     underflow;

  // Memory-read side plus pixel side as seen by the client driving the FIFO
  modport master (
    output flush, wr_data, wr_en, rd_en,
    input  full, afull, rd_data, rd_valid, empty, level, overflow, underflow
  );

  // The FIFO itself
  modport slave (
    input  flush, wr_data, wr_en, rd_en,
    output full, afull, rd_data, rd_valid, empty, level, overflow, underflow
  );
endinterface

// File: rtl/rd_fram_gearbox_fifo.sv
// Single-clock width-converting FIFO. Wide words are stored whole; the read
// side walks through the slices of the head word with sub_idx and frees the
// entry when its last slice leaves. Occupancy is tracked in wide words
// (wide_count) so full/afull are cheap; level is derived in slices.
module rd_fram_gearbox_fifo #(
  parameter int WR_DATA_WIDTH = 256,
  parameter int RD_DATA_WIDTH = 32,
  parameter int DEPTH         = 512,
  parameter bit OUTPUT_REG    = 1'b0,
  parameter bit LSB_FIRST     = 1'b1,
  parameter int AFULL_THRESH  = DEPTH - 4
) (
  input logic                   clk,
  input logic                   rst,
  rd_fram_gearbox_fifo_if.slave bus
);

  localparam int R   = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int SW  = $clog2(R);
  localparam int SIW = (SW > 0) ? SW : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + SW + 1;
  localparam int BW  = $clog2(WR_DATA_WIDTH);

  localparam logic [SIW-1:0] LAST_SUB  = SIW'(R - 1);
  localparam logic [SIW-1:0] SUB_ONE   = SIW'(1);
  localparam logic [AW:0]    PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    AFULL_CNT = (AW + 1)'(AFULL_THRESH);

  // Storage: no reset, contents are don't-care until written
  logic [WR_DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0]              wr_ptr_q, wr_ptr_d;
  logic [AW:0]              rd_ptr_q, rd_ptr_d;
  logic [SIW-1:0]           sub_idx_q, sub_idx_d;
  logic [AW:0]              wide_count_q, wide_count_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [RD_DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  logic                     full_s;
  logic                     afull_s;
  logic                     empty_s;
  logic [LW-1:0]            level_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     free_s;
  logic [SIW-1:0]           slice_sel_s;
  logic [BW-1:0]            slice_base_s;
  logic [WR_DATA_WIDTH-1:0] rd_word_s;
  logic [RD_DATA_WIDTH-1:0] rd_slice_s;
  logic                     ptr_msb_unused_s;

  // Pointer wrap bits only matter for the 2*DEPTH wrap, occupancy comes from wide_count
  assign ptr_msb_unused_s = wr_ptr_q[AW] ^ rd_ptr_q[AW];

  // Status flags from start-of-cycle registered state
  always_comb begin
    level_s = (LW'(wide_count_q) << SW) - LW'(sub_idx_q);
    empty_s = (level_s == {LW{1'b0}});
    full_s  = (wide_count_q == DEPTH_CNT);
    afull_s = (wide_count_q >= AFULL_CNT);
  end

  // Accept/free decode; flush overrides both handshakes
  always_comb begin
    push_s = bus.wr_en & ~full_s & ~bus.flush;
    pop_s  = bus.rd_en & ~empty_s & ~bus.flush;
    free_s = pop_s & (sub_idx_q == LAST_SUB);
  end

  // Pick the current slice of the head word
  always_comb begin
    if (LSB_FIRST) begin
      slice_sel_s = sub_idx_q;
    end else begin
      slice_sel_s = LAST_SUB - sub_idx_q;
    end
    slice_base_s = BW'(slice_sel_s) * BW'(RD_DATA_WIDTH);
    rd_word_s    = mem[rd_ptr_q[AW-1:0]];
    rd_slice_s   = rd_word_s[slice_base_s +: RD_DATA_WIDTH];
  end

  // Next-state for pointers, occupancy, sticky errors and the first read stage
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sub_idx_d    = sub_idx_q;
    wide_count_d = wide_count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    s1_valid_d   = pop_s;
    s1_data_d    = s1_data_q;

    if (pop_s) begin
      s1_data_d = rd_slice_s;
    end else begin
      s1_data_d = s1_data_q;
    end

    if (bus.flush) begin
      wr_ptr_d     = {(AW + 1){1'b0}};
      rd_ptr_d     = {(AW + 1){1'b0}};
      sub_idx_d    = {SIW{1'b0}};
      wide_count_d = {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        if (sub_idx_q == LAST_SUB) begin
          sub_idx_d = {SIW{1'b0}};
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end else begin
          sub_idx_d = sub_idx_q + SUB_ONE;
          rd_ptr_d  = rd_ptr_q;
        end
      end else begin
        sub_idx_d = sub_idx_q;
        rd_ptr_d  = rd_ptr_q;
      end

      case ({push_s, free_s})
        2'b10:   wide_count_d = wide_count_q + PTR_ONE;
        2'b01:   wide_count_d = wide_count_q - PTR_ONE;
        default: wide_count_d = wide_count_q;
      endcase

      if (bus.wr_en & full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      if (bus.rd_en & empty_s) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
    end
  end

  // Control/state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= {(AW + 1){1'b0}};
      rd_ptr_q     <= {(AW + 1){1'b0}};
      sub_idx_q    <= {SIW{1'b0}};
      wide_count_q <= {(AW + 1){1'b0}};
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_data_q    <= {RD_DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sub_idx_q    <= sub_idx_d;
      wide_count_q <= wide_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
    end
  end

  // Wide-word write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end
  end

  generate
    if (OUTPUT_REG) begin : g_out_reg
      logic                     s2_valid_q, s2_valid_d;
      logic [RD_DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      // Second stage follows the first; data holds between strobes
      always_comb begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_data_d = s1_data_q;
        end else begin
          s2_data_d = s2_data_q;
        end
      end

      // Extra output register, cleared by reset so in-flight strobes are dropped
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= {RD_DATA_WIDTH{1'b0}};
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign bus.rd_valid = s2_valid_q;
      assign bus.rd_data  = s2_data_q;
    end else begin : g_no_out_reg
      assign bus.rd_valid = s1_valid_q;
      assign bus.rd_data  = s1_data_q;
    end
  endgenerate

  assign bus.full      = full_s;
  assign bus.afull     = afull_s;
  assign bus.empty     = empty_s;
  assign bus.level     = level_s;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
